// File: rtl/pmmu.sv
// pmmu: instruction-side paged MMU between the fetch unit and the interconnect.
// Define PMMU_FAULT_EN to implement entry valid bits, page-fault reporting and the fault status SRs.
module pmmu #(
   parameter int                              RW         = 16,
   parameter int                              PC_ADDR_W  = 16,
   parameter int                              OUT_ADDR_W = 24,
   parameter int                              PAGE_IDX_W = 4,
   parameter logic [RW-1:0]                   SR_BASE    = 16'h100,
   parameter logic [OUT_ADDR_W-PC_ADDR_W-1:0] DIS_PREFIX = 8'h80
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_req,
   input  logic [PC_ADDR_W-1:0]             i_addr,
   input  logic                             c_pag_en,
   input  logic                             c_long_mode,
   input  logic [OUT_ADDR_W-PC_ADDR_W-1:0]  i_long_high_addr,
   output logic                             o_valid,
   output logic [OUT_ADDR_W-1:0]            o_addr,
   output logic                             o_fault,
   input  logic [RW-1:0]                    i_sr_addr,
   input  logic [RW-1:0]                    i_sr_data,
   input  logic                             i_sr_we,
   output logic [RW-1:0]                    o_sr_rdata
);

   localparam int PAGES   = 1 << PAGE_IDX_W;
   localparam int OFF_W   = PC_ADDR_W - PAGE_IDX_W;
   localparam int HI_W    = OUT_ADDR_W - PC_ADDR_W;
   localparam int FRAME_W = OUT_ADDR_W - OFF_W;
   localparam int ENTRY_W = FRAME_W + 1;
   localparam logic [FRAME_W-1:0] FRAME_ONES = {FRAME_W{1'b1}};

   logic [ENTRY_W-1:0]    entry_q [PAGES];
   logic [ENTRY_W-1:0]    entry_d [PAGES];
   logic [HI_W-1:0]       highOff_q, highOff_d;
   logic                  valid_q, valid_d;
   logic [OUT_ADDR_W-1:0] addr_q, addr_d;
   logic                  fault_q, fault_d;
   logic [RW-1:0]         rdata_q, rdata_d;

   logic [RW-1:0]         srRel;
   logic                  srInBlock, srIsEntry, srIsHighOff, srIsFaultSt, srIsFaultAddr;
   logic [PAGE_IDX_W-1:0] srIdx;
   logic [PAGE_IDX_W-1:0] pageIdx;
   logic [HI_W-1:0]       longHigh;
   logic                  entryValid;
   logic                  reqFault;
   logic [OUT_ADDR_W-1:0] xlatAddr;
   logic [RW-1:0]         faultStatus;
   logic [RW-1:0]         faultAddrRd;
   logic                  unusedSrData;

   assign srRel         = i_sr_addr - SR_BASE;
   assign srInBlock     = (i_sr_addr >= SR_BASE);
   assign srIsEntry     = srInBlock && (srRel < RW'(PAGES));
   assign srIsHighOff   = srInBlock && (srRel == RW'(PAGES));
   assign srIsFaultSt   = srInBlock && (srRel == RW'(PAGES + 1));
   assign srIsFaultAddr = srInBlock && (srRel == RW'(PAGES + 2));
   assign srIdx         = srRel[PAGE_IDX_W-1:0];
   assign unusedSrData  = ^i_sr_data;

   assign pageIdx  = i_addr[PC_ADDR_W-1 -: PAGE_IDX_W];
   assign longHigh = i_long_high_addr + highOff_q;

   // Long mode outranks paging; a faulting lookup returns a zero address.
   always_comb begin
      xlatAddr = '0;
      reqFault = 1'b0;
      if (c_long_mode) begin
         xlatAddr = {longHigh, i_addr};
      end else if (c_pag_en) begin
         if (entryValid) begin
            xlatAddr = {entry_q[pageIdx][FRAME_W-1:0], i_addr[OFF_W-1:0]};
         end else begin
            reqFault = 1'b1;
         end
      end else begin
         xlatAddr = {DIS_PREFIX, i_addr};
      end
   end

   always_comb begin
      valid_d = i_req;
      fault_d = i_req & reqFault;
      addr_d  = i_req ? xlatAddr : addr_q;
   end

   // SR writes land at the clock edge, so a same-cycle lookup still sees the old contents.
   always_comb begin
      entry_d   = entry_q;
      highOff_d = highOff_q;
      if (i_sr_we && srIsEntry) begin
         entry_d[srIdx] = ENTRY_W'(i_sr_data);
      end
      if (i_sr_we && srIsHighOff) begin
         highOff_d = HI_W'(i_sr_data);
      end
   end

`ifdef PMMU_FAULT_EN
   logic                  sticky_q, sticky_d;
   logic [PAGE_IDX_W-1:0] faultIdx_q, faultIdx_d;
   logic [PC_ADDR_W-1:0]  faultAddr_q, faultAddr_d;
   logic                  faultClr;
   logic                  newFault;

   assign entryValid = entry_q[pageIdx][ENTRY_W-1];
   assign faultClr   = i_sr_we && srIsFaultSt;
   assign newFault   = i_req && reqFault;

   // A new fault wins over a same-cycle status clear so that it is never lost.
   always_comb begin
      sticky_d    = sticky_q;
      faultIdx_d  = faultIdx_q;
      faultAddr_d = faultAddr_q;
      if (newFault && (!sticky_q || faultClr)) begin
         sticky_d    = 1'b1;
         faultIdx_d  = pageIdx;
         faultAddr_d = i_addr;
      end else if (faultClr) begin
         sticky_d   = 1'b0;
         faultIdx_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sticky_q    <= 1'b0;
         faultIdx_q  <= '0;
         faultAddr_q <= '0;
      end else begin
         sticky_q    <= sticky_d;
         faultIdx_q  <= faultIdx_d;
         faultAddr_q <= faultAddr_d;
      end
   end

   always_comb begin
      faultStatus                   = '0;
      faultStatus[RW-1]             = sticky_q;
      faultStatus[PAGE_IDX_W-1:0]   = faultIdx_q;
   end
   assign faultAddrRd = RW'(faultAddr_q);
`else
   assign entryValid  = 1'b1;
   assign faultStatus = '0;
   assign faultAddrRd = '0;
`endif

   always_comb begin
      rdata_d = '0;
      if (srIsEntry) begin
         rdata_d = RW'(entry_q[srIdx]);
      end else if (srIsHighOff) begin
         rdata_d = RW'(highOff_q);
      end else if (srIsFaultSt) begin
         rdata_d = faultStatus;
      end else if (srIsFaultAddr) begin
         rdata_d = faultAddrRd;
      end
   end

   // Entries 0 and 1 come up mapped to the top two frames so fetch can boot with paging on.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q   <= 1'b0;
         addr_q    <= '0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
         highOff_q <= '0;
         for (int i = 0; i < PAGES; i++) begin
            entry_q[i] <= '0;
         end
         entry_q[0] <= {1'b1, FRAME_ONES - FRAME_W'(1)};
         entry_q[1] <= {1'b1, FRAME_ONES};
      end else begin
         valid_q   <= valid_d;
         addr_q    <= addr_d;
         fault_q   <= fault_d;
         rdata_q   <= rdata_d;
         highOff_q <= highOff_d;
         entry_q   <= entry_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_addr     = addr_q;
   assign o_fault    = fault_q;
   assign o_sr_rdata = rdata_q;

endmodule

// File: tb/tb_pmmu.sv
// tb_pmmu: directed self-checking bench for pmmu; fault expectations follow PMMU_FAULT_EN.
module tb_pmmu;

`ifdef PMMU_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic        c_pag_en;
   logic        c_long_mode;
   logic [7:0]  i_long_high_addr;
   logic        o_valid;
   logic [23:0] o_addr;
   logic        o_fault;
   logic [15:0] i_sr_addr;
   logic [15:0] i_sr_data;
   logic        i_sr_we;
   logic [15:0] o_sr_rdata;

   int vectors = 0;
   int miscompares = 0;

   pmmu dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_req            (i_req),
      .i_addr           (i_addr),
      .c_pag_en         (c_pag_en),
      .c_long_mode      (c_long_mode),
      .i_long_high_addr (i_long_high_addr),
      .o_valid          (o_valid),
      .o_addr           (o_addr),
      .o_fault          (o_fault),
      .i_sr_addr        (i_sr_addr),
      .i_sr_data        (i_sr_data),
      .i_sr_we          (i_sr_we),
      .o_sr_rdata       (o_sr_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Drive one cycle of inputs, then return 1ns after the edge that consumed them.
   task automatic applyStimulus(input logic req, input logic [15:0] addr, input logic pag,
                                input logic lng, input logic [7:0] lhi, input logic [15:0] sra,
                                input logic [15:0] srd, input logic we);
      i_req            = req;
      i_addr           = addr;
      c_pag_en         = pag;
      c_long_mode      = lng;
      i_long_high_addr = lhi;
      i_sr_addr        = sra;
      i_sr_data        = srd;
      i_sr_we          = we;
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      applyStimulus(0, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 0);
      applyStimulus(0, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 0);
      checkOutput("rst_valid", 32'(o_valid), 32'h0);
      checkOutput("rst_addr", 32'(o_addr), 32'h0);
      checkOutput("rst_fault", 32'(o_fault), 32'h0);
      checkOutput("rst_rdata", 32'(o_sr_rdata), 32'h0);
      i_rst = 1'b0;

      applyStimulus(1, 16'h0123, 1, 0, 8'h00, 16'h0000, 16'h0000, 0);
      checkOutput("pg0_valid", 32'(o_valid), 32'h1);
      checkOutput("pg0_addr", 32'(o_addr), 32'hFFE123);
      applyStimulus(1, 16'h1FFE, 1, 0, 8'h00, 16'h0000, 16'h0000, 0);
      checkOutput("pg1_addr", 32'(o_addr), 32'hFFFFFE);

      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0103, 16'h1ABC, 1);
      checkOutput("idle_valid", 32'(o_valid), 32'h0);
      checkOutput("idle_hold", 32'(o_addr), 32'hFFFFFE);
      applyStimulus(1, 16'h3456, 1, 0, 8'h00, 16'h0103, 16'h0000, 0);
      checkOutput("pg3_addr", 32'(o_addr), 32'hABC456);
      checkOutput("pg3_fault", 32'(o_fault), 32'h0);
      checkOutput("rd_entry3", 32'(o_sr_rdata), 32'h1ABC);

      applyStimulus(1, 16'h0000, 1, 0, 8'h00, 16'h0000, 16'h0000, 0);
      checkOutput("b2b0_valid", 32'(o_valid), 32'h1);
      checkOutput("b2b0_addr", 32'(o_addr), 32'hFFE000);
      applyStimulus(1, 16'h3000, 1, 0, 8'h00, 16'h0000, 16'h0000, 0);
      checkOutput("b2b1_valid", 32'(o_valid), 32'h1);
      checkOutput("b2b1_addr", 32'(o_addr), 32'hABC000);

      applyStimulus(1, 16'h5000, 1, 0, 8'h00, 16'h0111, 16'h0000, 0);
      checkOutput("pg5_fault", 32'(o_fault), FAULT_EN ? 32'h1 : 32'h0);
      checkOutput("pg5_addr", 32'(o_addr), 32'h0);
      checkOutput("pg5_status_before", 32'(o_sr_rdata), 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0111, 16'h0000, 0);
      checkOutput("status_pg5", 32'(o_sr_rdata), FAULT_EN ? 32'h8005 : 32'h0);
      checkOutput("status_fault_clr", 32'(o_fault), 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0112, 16'h0000, 0);
      checkOutput("faddr_pg5", 32'(o_sr_rdata), FAULT_EN ? 32'h5000 : 32'h0);

      applyStimulus(1, 16'h6000, 1, 0, 8'h00, 16'h0111, 16'h0000, 0);
      checkOutput("pg6_fault", 32'(o_fault), FAULT_EN ? 32'h1 : 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0112, 16'h0000, 0);
      checkOutput("faddr_sticky", 32'(o_sr_rdata), FAULT_EN ? 32'h5000 : 32'h0);

      applyStimulus(1, 16'h7000, 1, 0, 8'h00, 16'h0111, 16'h0000, 1);
      checkOutput("clr_old_status", 32'(o_sr_rdata), FAULT_EN ? 32'h8005 : 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0111, 16'h0000, 0);
      checkOutput("set_wins_status", 32'(o_sr_rdata), FAULT_EN ? 32'h8007 : 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0112, 16'h0000, 0);
      checkOutput("set_wins_faddr", 32'(o_sr_rdata), FAULT_EN ? 32'h7000 : 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0111, 16'h1234, 1);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0111, 16'h0000, 0);
      checkOutput("status_cleared", 32'(o_sr_rdata), 32'h0);

      applyStimulus(0, 16'h0000, 0, 0, 8'h00, 16'h0110, 16'h0010, 1);
      applyStimulus(1, 16'h1234, 1, 1, 8'hF8, 16'h0110, 16'h0000, 0);
      checkOutput("long_wrap", 32'(o_addr), 32'h081234);
      checkOutput("rd_hoff", 32'(o_sr_rdata), 32'h0010);
      applyStimulus(1, 16'h1234, 1, 1, 8'hF8, 16'h0110, 16'h0020, 1);
      checkOutput("long_old_off", 32'(o_addr), 32'h081234);
      applyStimulus(1, 16'h1234, 0, 1, 8'hF8, 16'h0000, 16'h0000, 0);
      checkOutput("long_new_off", 32'(o_addr), 32'h181234);
      applyStimulus(1, 16'h1234, 0, 0, 8'hF8, 16'h0000, 16'h0000, 0);
      checkOutput("disabled", 32'(o_addr), 32'h801234);

      applyStimulus(1, 16'h0010, 1, 0, 8'h00, 16'h0100, 16'h1005, 1);
      checkOutput("entry_old", 32'(o_addr), 32'hFFE010);
      applyStimulus(1, 16'h0010, 1, 0, 8'h00, 16'h0000, 16'h0000, 0);
      checkOutput("entry_new", 32'(o_addr), 32'h005010);

      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0113, 16'hFFFF, 1);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0113, 16'h0000, 0);
      checkOutput("unmapped_hi", 32'(o_sr_rdata), 32'h0);
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h00FF, 16'h0000, 0);
      checkOutput("unmapped_lo", 32'(o_sr_rdata), 32'h0);

      applyStimulus(1, 16'h3123, 1, 0, 8'h00, 16'h0103, 16'h0000, 0);
      checkOutput("pre_rst_valid", 32'(o_valid), 32'h1);
      i_rst = 1'b1;
      applyStimulus(1, 16'h3123, 1, 0, 8'h00, 16'h0103, 16'h0000, 0);
      checkOutput("midrst_valid", 32'(o_valid), 32'h0);
      checkOutput("midrst_addr", 32'(o_addr), 32'h0);
      i_rst = 1'b0;
      applyStimulus(0, 16'h0000, 1, 0, 8'h00, 16'h0103, 16'h0000, 0);
      checkOutput("rst_entry3", 32'(o_sr_rdata), 32'h0);
      applyStimulus(1, 16'h0123, 1, 0, 8'h00, 16'h0100, 16'h0000, 0);
      checkOutput("rst_entry0", 32'(o_sr_rdata), 32'h1FFE);
      checkOutput("rst_pg0_addr", 32'(o_addr), 32'hFFE123);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pmmu.md
# pmmu

Parametrised instruction-side paged MMU for the ppcpu fetch path, placed between the fetch unit and the interconnect. It translates PC-space addresses to bus addresses through a special-register-programmable page table, a long-mode window or a fixed disabled-paging prefix. Compared with the previous-generation translator it has configurable widths and page count, a registered one-request-per-cycle pipeline, per-entry valid bits with page-fault reporting, and register read-back.

## Interface
Parameters:
- RW, 16, special-register data and address width.
- PC_ADDR_W, 16, input address width.
- OUT_ADDR_W, 24, output address width; must be greater than PC_ADDR_W.
- PAGE_IDX_W, 4, page index bits; PAGES = 2^PAGE_IDX_W; OFF_W = PC_ADDR_W-PAGE_IDX_W.
- SR_BASE, 16'h100, first SR address of the block.
- DIS_PREFIX, 8'h80, high bits used when paging is disabled; width OUT_ADDR_W-PC_ADDR_W.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  1  translation request valid.
- i_addr  in  PC_ADDR_W  address to translate.
- c_pag_en  in  1  paging enable, sampled with i_req.
- c_long_mode  in  1  long mode, sampled with i_req; has priority over c_pag_en.
- i_long_high_addr  in  OUT_ADDR_W-PC_ADDR_W  long-mode high part.
- o_valid  out  1  translation result valid.
- o_addr  out  OUT_ADDR_W  translated address.
- o_fault  out  1  page fault on the result shown this cycle.
- i_sr_addr  in  RW  SR address.
- i_sr_data  in  RW  SR write data.
- i_sr_we  in  1  SR write strobe.
- o_sr_rdata  out  RW  registered read of i_sr_addr.

## Operation
- FRAME_W = OUT_ADDR_W-OFF_W. Entry = {V, frame[FRAME_W-1:0]}, ENTRY_W = FRAME_W+1.
- SR map, relative to SR_BASE:
  - +0 to +PAGES-1: entries, write data[ENTRY_W-1:0].
  - +PAGES: high_addr_off, OUT_ADDR_W-PC_ADDR_W bits.
  - +PAGES+1: fault status; reads {0, sticky fault, fault page idx}; any write clears it.
  - +PAGES+2: faulting address, low RW bits, read-only.
  - Any other address: reads 0, writes ignored.
- Translation select, by priority:
  - long: {i_long_high_addr+high_addr_off mod 2^(OUT_ADDR_W-PC_ADDR_W), i_addr}.
  - paged: {frame[page_idx], i_addr[OFF_W-1:0]}.
  - disabled: {DIS_PREFIX, i_addr}.
- Fault condition: paged mode and the entry's V is 0. o_fault=1, o_addr=0.
- On a fault, if the sticky bit is clear: set it and capture the page index and address. Later faults do not overwrite the capture until the sticky bit is cleared.

## Timing
- Reset:
  - o_valid=0, o_addr=0, o_fault=0, o_sr_rdata=0.
  - high_addr_off=0, fault status and fault address cleared.
  - Entry 0 = {1, all-ones-1}, entry 1 = {1, all-ones}, all other entries 0 (invalid).
- Latency: i_req in cycle N produces o_valid/o_addr/o_fault in cycle N+1.
  - Fully pipelined: one request per cycle, no stall.
  - o_valid=0 when no request was accepted in the previous cycle; o_addr holds its last value.
- Entry write and lookup of the same entry in the same cycle: the lookup uses the old entry. The new value applies from the next request.
- high_addr_off write in the same cycle as a long-mode request: the request uses the old offset.
- New fault and a fault-status clear in the same cycle: the set wins and the new fault is captured.
- o_sr_rdata reflects register contents at cycle N for i_sr_addr at N, presented at N+1. If a write and a read of the same address occur at N, the old value is returned.
- i_rst asserted mid-stream: the pending result is discarded and o_valid=0 in the next cycle.

## Configuration
- PMMU_FAULT_EN defined:
  - V bits, fault detection and fault SRs are implemented as described above.
- PMMU_FAULT_EN undefined:
  - V is treated as 1 for all lookups, so paged translation always uses the frame.
  - o_fault is tied 0.
  - SRs +PAGES+1 and +PAGES+2 read 0 and ignore writes.

## Test plan
- After reset, paged mode, i_req with i_addr=0x0123 -> next cycle o_valid=1, o_addr=0xFFE123; i_addr=0x1FFE -> 0xFFFFFE.
- SR write 0x103=0x1ABC, then paged request 0x3456 -> o_addr=0xABC456, o_fault=0. Back-to-back requests 0x0000, 0x3000 -> two consecutive valid results.
- Paged request 0x5000 after reset (PMMU_FAULT_EN) -> o_fault=1, o_addr=0. SR read 0x111 -> 0x8005, SR 0x112 -> 0x5000. Write 0x111 -> it reads 0.
- Long mode, SR 0x110=0x10, i_long_high_addr=0xF8, i_addr=0x1234 -> o_addr=0x081234 (wrap); disabled paging with i_addr=0x1234 -> 0x801234.
- Same-cycle SR write 0x100=0x1005 and paged request 0x0010 -> 0xFFE010. Next request 0x0010 -> 0x005010.
- Assert i_rst the cycle after a request -> o_valid=0, and entry 3 reads back 0.
